// File: rtl/a_regfile_scoreboard_if.sv
// Writeback/decode-facing bundle of the register file scoreboard.
// The master drives writeback and decode requests; the slave is the register file.
interface a_regfile_scoreboard_if #(
    parameter int DATA_W = 32
);
    logic              wb_RegWEN;
    logic [4:0]        wb_Rw;
    logic [DATA_W-1:0] wb_port_w;
    logic              wb_halt;
    logic [4:0]        rsel1;
    logic [4:0]        rsel2;
    logic [DATA_W-1:0] rdat1;
    logic [DATA_W-1:0] rdat2;
    logic              issue_en;
    logic [4:0]        issue_rd;
    logic              flush;
    logic              busy1;
    logic              busy2;
    logic              sb_overflow;
    logic              halt_out;
    logic [31:0]       write_count;

    modport master (
        output wb_RegWEN, wb_Rw, wb_port_w, wb_halt,
        output rsel1, rsel2, issue_en, issue_rd, flush,
        input  rdat1, rdat2, busy1, busy2, sb_overflow, halt_out, write_count
    );

    modport slave (
        input  wb_RegWEN, wb_Rw, wb_port_w, wb_halt,
        input  rsel1, rsel2, issue_en, issue_rd, flush,
        output rdat1, rdat2, busy1, busy2, sb_overflow, halt_out, write_count
    );
endinterface

// File: rtl/a_regfile_scoreboard.sv
// 32-entry register file with write-through bypass, per-register pending-write
// scoreboard for decode stalls, sticky halt latch and committed-write counter.
module a_regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int PEND_W = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    a_regfile_scoreboard_if.slave  bus
);
    localparam int              NREG    = 32;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [PEND_W-1:0] cnt_q  [NREG];
    logic [PEND_W-1:0] cnt_d  [NREG];
    logic              halt_q, halt_d;
    logic              ovf_q,  ovf_d;
    logic [31:0]       wcnt_q, wcnt_d;

    logic              we;
    logic [NREG-1:0]   inc_vec;
    logic [NREG-1:0]   wb_vec;

    // Once halted, the writeback side is frozen: no writes, decrements or counts.
    assign we = bus.wb_RegWEN && (bus.wb_Rw != 5'd0) && !halt_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        inc_vec = '0;
        wb_vec  = '0;
        if (bus.issue_en && bus.issue_rd != 5'd0) inc_vec[bus.issue_rd] = 1'b1;
        if (we)                                   wb_vec[bus.wb_Rw]     = 1'b1;
    end

    // NOTE: combinational next-state uses blocking '='; the state registers below use '<='.
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[bus.wb_Rw] = bus.wb_port_w;
        regs_d[0] = '0;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        for (int i = 1; i < NREG; i++) begin
            if (bus.flush) begin
                cnt_d[i] = '0;
            end else if (inc_vec[i] && wb_vec[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i];
            end else if (inc_vec[i]) begin
                if (cnt_q[i] == CNT_MAX) ovf_d = 1'b1;
                else                     cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else if (wb_vec[i] && cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        halt_d = halt_q || bus.wb_halt;
        wcnt_d = we ? wcnt_q + 32'd1 : wcnt_q;
    end

    // NOTE: the register array is reset because software expects every register to read 0 after reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            halt_q <= 1'b0;
            ovf_q  <= 1'b0;
            wcnt_q <= '0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            halt_q <= halt_d;
            ovf_q  <= ovf_d;
            wcnt_q <= wcnt_d;
        end
    end

    // Read ports: r0 is hard zero, a same-cycle write is forwarded.
    always_comb begin
        bus.rdat1 = regs_q[bus.rsel1];
        if (we && bus.wb_Rw == bus.rsel1) bus.rdat1 = bus.wb_port_w;
        if (bus.rsel1 == 5'd0)            bus.rdat1 = '0;

        bus.rdat2 = regs_q[bus.rsel2];
        if (we && bus.wb_Rw == bus.rsel2) bus.rdat2 = bus.wb_port_w;
        if (bus.rsel2 == 5'd0)            bus.rdat2 = '0;
    end

    // A last outstanding write landing this cycle is covered by the bypass.
    always_comb begin
        bus.busy1 = (cnt_q[bus.rsel1] != '0) &&
                    !(cnt_q[bus.rsel1] == CNT_ONE && we && bus.wb_Rw == bus.rsel1);
        bus.busy2 = (cnt_q[bus.rsel2] != '0) &&
                    !(cnt_q[bus.rsel2] == CNT_ONE && we && bus.wb_Rw == bus.rsel2);
    end

    assign bus.sb_overflow = ovf_q;
    assign bus.halt_out    = halt_q;
    assign bus.write_count = wcnt_q;
endmodule

// File: tb/tb_a_regfile_scoreboard.sv
// Directed self-checking bench for a_regfile_scoreboard: writes, bypass,
// scoreboard counting/overflow/flush, halt freeze and asynchronous reset.
module tb_a_regfile_scoreboard;
    logic CLK;
    logic nRST;
    int   errors = 0;
    int   checks = 0;

    a_regfile_scoreboard_if #(.DATA_W(32)) bus_if ();

    a_regfile_scoreboard #(.DATA_W(32), .PEND_W(2)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus_if.wb_RegWEN = 1'b0;
        bus_if.wb_Rw     = 5'd0;
        bus_if.wb_port_w = '0;
        bus_if.wb_halt   = 1'b0;
        bus_if.issue_en  = 1'b0;
        bus_if.issue_rd  = 5'd0;
        bus_if.flush     = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        bus_if.wb_RegWEN = 1'b1;
        bus_if.wb_Rw     = rd;
        bus_if.wb_port_w = d;
    endtask

    initial begin
        idle();
        bus_if.rsel1 = 5'd0;
        bus_if.rsel2 = 5'd0;
        nRST = 1'b0;
        #12;
        check("rst_wcount", bus_if.write_count, 32'd0);
        check("rst_halt",   {31'd0, bus_if.halt_out}, 32'd0);
        check("rst_ovf",    {31'd0, bus_if.sb_overflow}, 32'd0);
        nRST = 1'b1;
        tick();

        // Basic write and readback
        wb(5'd5, 32'hDEADBEEF);
        tick();
        idle();
        bus_if.rsel1 = 5'd5;
        #1;
        check("r5_read",  bus_if.rdat1, 32'hDEADBEEF);
        check("wcount_1", bus_if.write_count, 32'd1);

        // Register 0 is never written
        wb(5'd0, 32'h00001234);
        bus_if.rsel1 = 5'd0;
        #1;
        check("r0_bypass", bus_if.rdat1, 32'd0);
        tick();
        idle();
        #1;
        check("r0_read",    bus_if.rdat1, 32'd0);
        check("r0_wcount",  bus_if.write_count, 32'd1);

        // Same-cycle bypass
        bus_if.rsel1 = 5'd5;
        bus_if.rsel2 = 5'd7;
        wb(5'd7, 32'hA5A5A5A5);
        #1;
        check("bypass_r7", bus_if.rdat2, 32'hA5A5A5A5);
        check("other_r5",  bus_if.rdat1, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("r7_read",  bus_if.rdat2, 32'hA5A5A5A5);
        check("wcount_2", bus_if.write_count, 32'd2);

        // Scoreboard: two issues to r3, then two writebacks
        bus_if.rsel1 = 5'd3;
        bus_if.issue_en = 1'b1;
        bus_if.issue_rd = 5'd3;
        tick();
        tick();
        idle();
        #1;
        check("busy_cnt2",  {31'd0, bus_if.busy1}, 32'd1);
        check("busy2_r7",   {31'd0, bus_if.busy2}, 32'd0);
        wb(5'd3, 32'h33);
        #1;
        check("busy_wb_cnt2", {31'd0, bus_if.busy1}, 32'd1);
        tick();
        wb(5'd3, 32'h34);
        #1;
        check("busy_bypass", {31'd0, bus_if.busy1}, 32'd0);
        check("rdat_bypass", bus_if.rdat1, 32'h34);
        tick();
        idle();
        #1;
        check("busy_cnt0", {31'd0, bus_if.busy1}, 32'd0);
        check("wcount_4",  bus_if.write_count, 32'd4);

        // Overflow: four issues to a 2-bit counter
        bus_if.issue_en = 1'b1;
        bus_if.issue_rd = 5'd3;
        tick();
        tick();
        tick();
        check("ovf_before", {31'd0, bus_if.sb_overflow}, 32'd0);
        tick();
        idle();
        #1;
        check("ovf_set", {31'd0, bus_if.sb_overflow}, 32'd1);
        wb(5'd3, 32'h35);
        tick();
        tick();
        idle();
        #1;
        check("cnt_held3", {31'd0, bus_if.busy1}, 32'd1);
        check("wcount_6",  bus_if.write_count, 32'd6);
        bus_if.flush    = 1'b1;
        bus_if.issue_en = 1'b1;
        bus_if.issue_rd = 5'd3;
        tick();
        idle();
        #1;
        check("flush_busy", {31'd0, bus_if.busy1}, 32'd0);
        check("ovf_sticky", {31'd0, bus_if.sb_overflow}, 32'd1);

        // Simultaneous issue and writeback on r9 with cnt=1
        bus_if.rsel1    = 5'd9;
        bus_if.issue_en = 1'b1;
        bus_if.issue_rd = 5'd9;
        tick();
        wb(5'd9, 32'h99);
        #1;
        check("r9_same_busy", {31'd0, bus_if.busy1}, 32'd0);
        tick();
        idle();
        #1;
        check("r9_busy_next", {31'd0, bus_if.busy1}, 32'd1);
        check("r9_read",      bus_if.rdat1, 32'h99);
        check("wcount_7",     bus_if.write_count, 32'd7);
        wb(5'd9, 32'h9A);
        tick();
        idle();
        #1;
        check("r9_busy_done", {31'd0, bus_if.busy1}, 32'd0);

        // Halt: accompanying write lands, later writes are dropped
        bus_if.rsel1   = 5'd4;
        bus_if.rsel2   = 5'd10;
        wb(5'd4, 32'h77);
        bus_if.wb_halt = 1'b1;
        tick();
        idle();
        #1;
        check("halt_set",   {31'd0, bus_if.halt_out}, 32'd1);
        check("r4_halt_wr", bus_if.rdat1, 32'h77);
        check("wcount_9",   bus_if.write_count, 32'd9);
        wb(5'd4, 32'h88);
        #1;
        check("halt_nobyp", bus_if.rdat1, 32'h77);
        tick();
        idle();
        #1;
        check("halt_r4",     bus_if.rdat1, 32'h77);
        check("halt_wcount", bus_if.write_count, 32'd9);
        bus_if.issue_en = 1'b1;
        bus_if.issue_rd = 5'd10;
        tick();
        idle();
        wb(5'd10, 32'hAA);
        #1;
        check("halt_busy_wb", {31'd0, bus_if.busy2}, 32'd1);
        tick();
        idle();
        #1;
        check("halt_nodec", {31'd0, bus_if.busy2}, 32'd1);

        // Asynchronous reset mid-run
        nRST = 1'b0;
        #1;
        check("arst_r4",     bus_if.rdat1, 32'd0);
        check("arst_busy",   {31'd0, bus_if.busy2}, 32'd0);
        check("arst_halt",   {31'd0, bus_if.halt_out}, 32'd0);
        check("arst_ovf",    {31'd0, bus_if.sb_overflow}, 32'd0);
        check("arst_wcount", bus_if.write_count, 32'd0);
        #3;
        nRST = 1'b1;
        tick();
        wb(5'd4, 32'h55);
        tick();
        idle();
        #1;
        check("post_rst_r4", bus_if.rdat1, 32'h55);
        check("post_rst_wc", bus_if.write_count, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
